// File: rtl/digit_dec_pkg.sv
// Shared types and default sizes for the classifier argmax stage and its sequencer.
package digit_dec_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_MATS     = 10;
  localparam int DEF_IDX_W      = $clog2(DEF_N_MATS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } ctrl_state_t;

  // Argmax result as exchanged with digit_dec.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] val;
    logic [DEF_IDX_W-1:0]      idx;
  } result_t;

endpackage

// File: rtl/digit_dec_wdog.sv
// Loadable down-counter guarding the WAIT state of digit_dec_ctrl.
// Only instantiated when DIGIT_DEC_CTRL_WDOG_EN is defined.
module digit_dec_wdog #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/digit_dec_ctrl.sv
// Sequencer: gathers N_MATS serial class sums, launches them into digit_dec, holds the result.
// Optional WAIT watchdog and wdog_err port are enabled by defining DIGIT_DEC_CTRL_WDOG_EN.
module digit_dec_ctrl
  import digit_dec_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int N_MATS      = DEF_N_MATS,
  parameter  int TIMEOUT_CYC = 32,
  localparam int IDX_W       = $clog2(N_MATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sum_in,
  input  logic                  sum_valid,
  input  logic                  sum_last,
  output logic                  sum_ready,
  output logic [DATA_WIDTH-1:0] dec_sum [N_MATS],
  output logic                  dec_valid_in,
  input  logic [DATA_WIDTH-1:0] dec_max,
  input  logic [IDX_W-1:0]      dec_index,
  input  logic                  dec_valid_out,
  output logic [IDX_W-1:0]      res_digit,
  output logic [DATA_WIDTH-1:0] res_max,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  proto_err,
  output logic [15:0]           frame_cnt
`ifdef DIGIT_DEC_CTRL_WDOG_EN
  ,
  output logic                  wdog_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MATS - 1);

  ctrl_state_t           state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      res_digit_q, res_digit_d;
  logic [DATA_WIDTH-1:0] res_max_q, res_max_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  proto_err_q, proto_err_d;
  logic                  sum_ready_q, dec_valid_in_q, res_valid_q;
  logic                  beat_acc, at_last, timeout;

  assign beat_acc = sum_valid && sum_ready_q;
  assign at_last  = (cnt_q == LAST_IDX);

`ifdef DIGIT_DEC_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

  logic wdog_err_q, wdog_err_d;

  // Loaded in LAUNCH so it reaches zero on the TIMEOUT_CYC-th WAIT cycle.
  digit_dec_wdog #(
    .CNT_W(WDOG_W)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == LAUNCH),
    .load_val_i(WDOG_W'(TIMEOUT_CYC - 1)),
    .en_i      (state_q == WAIT),
    .expired_o (timeout)
  );

  assign wdog_err = wdog_err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_digit_d = res_digit_q;
    res_max_d   = res_max_q;
    frame_cnt_d = frame_cnt_q;
    proto_err_d = 1'b0;
`ifdef DIGIT_DEC_CTRL_WDOG_EN
    wdog_err_d  = wdog_err_q;
`endif
    case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          if (at_last && sum_last) begin
            cnt_d   = '0;
            state_d = LAUNCH;
          end else if (at_last || sum_last) begin
            // Framing disagrees with the producer: drop the partial frame.
            cnt_d       = '0;
            proto_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (dec_valid_out) begin
          res_digit_d = dec_index;
          res_max_d   = dec_max;
          state_d     = HOLD;
        end else if (timeout) begin
          res_digit_d = '0;
          res_max_d   = '0;
          state_d     = HOLD;
`ifdef DIGIT_DEC_CTRL_WDOG_EN
          wdog_err_d  = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (res_valid_q && res_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          cnt_d       = '0;
          state_d     = COLLECT;
`ifdef DIGIT_DEC_CTRL_WDOG_EN
          wdog_err_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      res_digit_q    <= '0;
      res_max_q      <= '0;
      frame_cnt_q    <= '0;
      proto_err_q    <= 1'b0;
      sum_ready_q    <= 1'b0;
      dec_valid_in_q <= 1'b0;
      res_valid_q    <= 1'b0;
`ifdef DIGIT_DEC_CTRL_WDOG_EN
      wdog_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      res_digit_q    <= res_digit_d;
      res_max_q      <= res_max_d;
      frame_cnt_q    <= frame_cnt_d;
      proto_err_q    <= proto_err_d;
      sum_ready_q    <= (state_d == COLLECT);
      dec_valid_in_q <= (state_d == LAUNCH);
      res_valid_q    <= (state_d == HOLD);
`ifdef DIGIT_DEC_CTRL_WDOG_EN
      wdog_err_q     <= wdog_err_d;
`endif
    end
  end

  // Slots are only written in COLLECT, so dec_sum is frozen through LAUNCH and WAIT.
  for (genvar gi = 0; gi < N_MATS; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (beat_acc && (cnt_q == IDX_W'(gi))) begin
        slot_q <= sum_in;
      end
    end

    assign dec_sum[gi] = slot_q;
  end

  assign sum_ready    = sum_ready_q;
  assign dec_valid_in = dec_valid_in_q;
  assign res_digit    = res_digit_q;
  assign res_max      = res_max_q;
  assign res_valid    = res_valid_q;
  assign proto_err    = proto_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_digit_dec_ctrl.sv
// Self-checking bench for digit_dec_ctrl with a behavioural argmax unit and a result scoreboard.
`timescale 1ns/1ps
module tb_digit_dec_ctrl;
  import digit_dec_pkg::*;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 4;

  typedef logic [DW-1:0] frame_t [N];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sum_in = '0;
  logic          sum_valid = 1'b0;
  logic          sum_last = 1'b0;
  logic          sum_ready;
  logic [DW-1:0] dec_sum [N];
  logic          dec_valid_in;
  logic [DW-1:0] dec_max = '0;
  logic [IW-1:0] dec_index = '0;
  logic          dec_valid_out = 1'b0;
  logic [IW-1:0] res_digit;
  logic [DW-1:0] res_max;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          proto_err;
  logic [15:0]   frame_cnt;
`ifdef DIGIT_DEC_CTRL_WDOG_EN
  logic          wdog_err;
`endif

  int      n_cmp = 0;
  int      n_fail = 0;
  int      exp_frames = 0;
  result_t exp_q[$];

  always #5 clk = ~clk;

  digit_dec_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sum_in       (sum_in),
    .sum_valid    (sum_valid),
    .sum_last     (sum_last),
    .sum_ready    (sum_ready),
    .dec_sum      (dec_sum),
    .dec_valid_in (dec_valid_in),
    .dec_max      (dec_max),
    .dec_index    (dec_index),
    .dec_valid_out(dec_valid_out),
    .res_digit    (res_digit),
    .res_max      (res_max),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .proto_err    (proto_err),
    .frame_cnt    (frame_cnt)
`ifdef DIGIT_DEC_CTRL_WDOG_EN
    ,
    .wdog_err     (wdog_err)
`endif
  );

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  function automatic result_t ref_argmax(input frame_t v);
    result_t r;
    r.val = v[0];
    r.idx = '0;
    for (int i = 1; i < N; i++) begin
      if (v[i] > r.val) begin
        r.val = v[i];
        r.idx = IW'(i);
      end
    end
    return r;
  endfunction

  task automatic rand_frame(output frame_t v);
    for (int i = 0; i < N; i++) v[i] = DW'($urandom_range(0, 4000));
  endtask

  // Drives beats first..last_beat, one per accepted cycle; sum_last on beat last_at.
  task automatic send_frame(input frame_t v, input int first, input int last_beat, input int last_at);
    int w;
    for (int i = first; i <= last_beat; i++) begin
      @(negedge clk);
      sum_valid = 1'b1;
      sum_in    = v[i];
      sum_last  = (i == last_at);
      w = 0;
      while (!sum_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        n_cmp++; n_fail++;
        $display("FAIL send_ready_timeout: sum_ready=%0b after %0d cycles, required 1", sum_ready, w);
      end
      @(posedge clk);
    end
  endtask

  // Argmax unit model: observes the launch pulse, then answers after lat cycles if respond.
  task automatic launch_respond(input int lat, input bit respond, output int dl, output int dw);
    logic [DW-1:0] mx;
    logic [IW-1:0] ix;
    dl = 0;
    dw = 0;
    @(negedge clk);
    sum_valid = 1'b0;
    sum_last  = 1'b0;
    while (!dec_valid_in && dl < 20) begin
      @(negedge clk);
      dl++;
    end
    while (dec_valid_in && dw < 5) begin
      dw++;
      @(negedge clk);
    end
    if (respond) begin
      mx = dec_sum[0];
      ix = '0;
      for (int i = 1; i < N; i++) begin
        if (dec_sum[i] > mx) begin
          mx = dec_sum[i];
          ix = IW'(i);
        end
      end
      repeat (lat) @(negedge clk);
      dec_valid_out = 1'b1;
      dec_max       = mx;
      dec_index     = ix;
      @(negedge clk);
      dec_valid_out = 1'b0;
      dec_max       = DW'($urandom);
      dec_index     = IW'($urandom_range(0, N - 1));
    end
  endtask

  // Full well-formed frame: decode, scoreboard compare, handshake, frame count.
  task automatic test_frame(input frame_t v, input result_t e_in, input int lat, input string tag);
    int      dl, dw;
    result_t e;
    exp_q.push_back(e_in);
    send_frame(v, 0, N - 1, N - 1);
    launch_respond(lat, 1'b1, dl, dw);
    n_cmp++; if (dl !== 0) begin n_fail++; $display("FAIL %s_launch_latency: got %0d cycles, required 0", tag, dl); end
    n_cmp++; if (dw !== 1) begin n_fail++; $display("FAIL %s_launch_width: got %0d cycles, required 1", tag, dw); end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL %s_res_valid: got %0b, required 1", tag, res_valid); end
    n_cmp++; if (sum_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_in_hold: got %0b, required 0", tag, sum_ready); end
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_scoreboard_empty: got result with no expectation, required one", tag);
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (res_digit !== e.idx) begin n_fail++; $display("FAIL %s_digit: got %0d, required %0d", tag, res_digit, e.idx); end
      n_cmp++; if (res_max !== e.val) begin n_fail++; $display("FAIL %s_max: got %0d, required %0d", tag, res_max, e.val); end
    end
    $display("frame %s: digit=%0d max=%0d", tag, res_digit, res_max);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_frames++;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL %s_res_valid_drop: got %0b, required 0", tag, res_valid); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL %s_frame_cnt: got %0d, required %0d", tag, frame_cnt, exp_frames); end
    n_cmp++; if (sum_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_after: got %0b, required 1", tag, sum_ready); end
  endtask

  task automatic test_reset;
    logic any_nz;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    any_nz = 1'b0;
    for (int i = 0; i < N; i++) any_nz |= (dec_sum[i] != '0);
    n_cmp++; if (sum_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sum_ready: got %0b, required 0", sum_ready); end
    n_cmp++; if ({dec_valid_in, res_valid, proto_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %03b, required 000", {dec_valid_in, res_valid, proto_err}); end
    n_cmp++; if ({res_digit, res_max, frame_cnt} !== '0) begin n_fail++; $display("FAIL rst_regs: digit=%0d max=%0d cnt=%0d, required 0", res_digit, res_max, frame_cnt); end
    n_cmp++; if (any_nz !== 1'b0) begin n_fail++; $display("FAIL rst_dec_sum: nonzero=%0b, required 0", any_nz); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (sum_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b, required 1", sum_ready); end
  endtask

  task automatic test_single_frame;
    frame_t v;
    v = '{16'd5, 16'd9, 16'd3, 16'd40, 16'd2, 16'd7, 16'd1, 16'd0, 16'd8, 16'd6};
    test_frame(v, '{val: 16'd40, idx: 4'd3}, 2, "single");
  endtask

  task automatic test_back_to_back;
    frame_t  v, v2;
    result_t e, e2;
    int      dl, dw;
    bit      stable;
    rand_frame(v);
    rand_frame(v2);
    e  = ref_argmax(v);
    e2 = ref_argmax(v2);
    exp_q.push_back(e);
    send_frame(v, 0, N - 1, N - 1);
    launch_respond(0, 1'b1, dl, dw);
    e = exp_q.pop_front();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_res_valid: got %0b, required 1", res_valid); end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_digit !== e.idx || res_max !== e.val || sum_ready !== 1'b0) stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold_stable: digit=%0d max=%0d, required %0d/%0d held", res_digit, res_max, e.idx, e.val); end
    $display("frame bp: digit=%0d max=%0d", res_digit, res_max);
    // Handshake with the next frame's first beat already offered.
    res_ready = 1'b1;
    sum_valid = 1'b1;
    sum_in    = v2[0];
    sum_last  = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    exp_frames++;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_res_valid_drop: got %0b, required 0", res_valid); end
    n_cmp++; if (sum_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_next: got %0b, required 1", sum_ready); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    @(posedge clk);
    exp_q.push_back(e2);
    send_frame(v2, 1, N - 1, N - 1);
    launch_respond(3, 1'b1, dl, dw);
    e2 = exp_q.pop_front();
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp2_res_valid: got %0b, required 1", res_valid); end
    n_cmp++; if (res_digit !== e2.idx || res_max !== e2.val) begin n_fail++; $display("FAIL bp2_result: got %0d/%0d, required %0d/%0d", res_digit, res_max, e2.idx, e2.val); end
    $display("frame bp2: digit=%0d max=%0d", res_digit, res_max);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_frames++;
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL bp2_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_proto_err;
    frame_t v, v2;
    rand_frame(v);
    send_frame(v, 0, 4, 4);
    @(negedge clk);
    sum_valid = 1'b0;
    sum_last  = 1'b0;
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL early_last_pulse: got %0b, required 1", proto_err); end
    n_cmp++; if (sum_ready !== 1'b1 || dec_valid_in !== 1'b0) begin n_fail++; $display("FAIL early_last_state: ready=%0b launch=%0b, required 1/0", sum_ready, dec_valid_in); end
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL early_last_width: got %0b, required 0", proto_err); end
    $display("frame early_last: proto_err observed");
    send_frame(v, 0, N - 1, -1);
    @(negedge clk);
    sum_valid = 1'b0;
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL missing_last_pulse: got %0b, required 1", proto_err); end
    n_cmp++; if (dec_valid_in !== 1'b0) begin n_fail++; $display("FAIL missing_last_launch: got %0b, required 0", dec_valid_in); end
    n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL proto_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
    $display("frame missing_last: proto_err observed");
    rand_frame(v2);
    test_frame(v2, ref_argmax(v2), 1, "after_proto");
  endtask

  task automatic test_tie;
    frame_t v;
    v = '{16'd1, 16'd3, 16'd50, 16'd4, 16'd0, 16'd9, 16'd10, 16'd50, 16'd2, 16'd7};
    test_frame(v, '{val: 16'd50, idx: 4'd2}, 0, "tie");
  endtask

`ifdef DIGIT_DEC_CTRL_WDOG_EN
  task automatic test_wdog;
    frame_t v;
    int     dl, dw, n;
    rand_frame(v);
    send_frame(v, 0, N - 1, N - 1);
    launch_respond(0, 1'b0, dl, dw);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL wdog_delay: got %0d cycles, required 32", n); end
    n_cmp++; if (wdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_err_set: got %0b, required 1", wdog_err); end
    n_cmp++; if (res_digit !== '0 || res_max !== '0) begin n_fail++; $display("FAIL wdog_result: got %0d/%0d, required 0/0", res_digit, res_max); end
    $display("frame wdog: digit=%0d max=%0d wdog_err=%0b", res_digit, res_max, wdog_err);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_frames = 0;
    n_cmp++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wdog_frame_wrap: got %0h, required 0", frame_cnt); end
    n_cmp++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_err_clear: got %0b, required 0", wdog_err); end
  endtask
`endif

  task automatic test_reset_mid_wait;
    frame_t v, v2;
    int     dl, dw;
    bit     seen;
    logic   any_nz;
    rand_frame(v);
    send_frame(v, 0, N - 1, N - 1);
    launch_respond(0, 1'b0, dl, dw);
    n_cmp++; if (dl !== 0) begin n_fail++; $display("FAIL rmw_launch_latency: got %0d, required 0", dl); end
    rst_n = 1'b0;
    @(negedge clk);
    any_nz = 1'b0;
    for (int i = 0; i < N; i++) any_nz |= (dec_sum[i] != '0);
    n_cmp++; if (sum_ready !== 1'b0 || res_valid !== 1'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmw_in_reset: ready=%0b valid=%0b cnt=%0d, required 0/0/0", sum_ready, res_valid, frame_cnt); end
    n_cmp++; if (any_nz !== 1'b0) begin n_fail++; $display("FAIL rmw_dec_sum: nonzero=%0b, required 0", any_nz); end
    rst_n = 1'b1;
    exp_frames = 0;
    @(negedge clk);
    dec_valid_out = 1'b1;
    dec_max       = 16'd999;
    dec_index     = 4'd5;
    @(negedge clk);
    dec_valid_out = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmw_stray_result: res_valid seen=%0b, required 0", seen); end
    n_cmp++; if (frame_cnt !== 16'd0 || sum_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_after: cnt=%0d ready=%0b, required 0/1", frame_cnt, sum_ready); end
    $display("frame reset_mid_wait: stray result ignored");
    rand_frame(v2);
    test_frame(v2, ref_argmax(v2), 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_proto_err();
    test_tie();
`ifdef DIGIT_DEC_CTRL_WDOG_EN
    test_wdog();
`endif
    test_reset_mid_wait();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_dec_ctrl.md
# digit_dec_ctrl

Sequencer for the classifier argmax stage. It collects the `N_MATS` per-class sums that the final fully-connected layer emits serially, one class per beat. It then launches them as one parallel vector into the `digit_dec` argmax unit and waits for that unit's result. The predicted digit and its score are presented downstream on a valid/ready handshake, and the block counts completed frames.

## Interface
- `DATA_WIDTH`, 16: width of each class sum and of the max score.
- `N_MATS`, 10: number of classes per frame.
- `IDX_W`, `$clog2(N_MATS)`: index width (derived, not overridable).
- `TIMEOUT_CYC`, 32: watchdog limit in WAIT; only used when `DIGIT_DEC_CTRL_WDOG_EN` is defined.
- `clk` in 1: single clock; all logic is posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sum_in` in DATA_WIDTH: class sum for the current beat. Class order is 0..N_MATS-1.
- `sum_valid` in 1: a beat is offered.
- `sum_last` in 1: marks the beat the producer considers final.
- `sum_ready` out 1: the block can accept a beat.
- `dec_sum` out DATA_WIDTH × [N_MATS]: unpacked buffer driven to the argmax unit.
- `dec_valid_in` out 1: one-cycle launch pulse to the argmax unit.
- `dec_max` in DATA_WIDTH: score returned by the argmax unit.
- `dec_index` in IDX_W: winning class returned by the argmax unit.
- `dec_valid_out` in 1: the argmax result is valid this cycle.
- `res_digit` out IDX_W: registered winning class.
- `res_max` out DATA_WIDTH: registered winning score.
- `res_valid` out 1: a result is held for downstream.
- `res_ready` in 1: downstream accepts the result.
- `proto_err` out 1: one-cycle pulse on a `sum_last` mismatch.
- `frame_cnt` out 16: number of completed frames; wraps.
- `wdog_err` out 1: present only with the macro; set when the held result was produced by a timeout.

## Operation
- States are COLLECT, LAUNCH, WAIT and HOLD. Reset enters COLLECT.
- COLLECT: `sum_ready`=1.
  - Each beat with `sum_valid`&&`sum_ready` writes `dec_sum[cnt]` and increments `cnt` (0..N_MATS-1).
  - If the beat at `cnt`==N_MATS-1 has `sum_last`=1, go to LAUNCH.
  - `sum_last`=1 with `cnt`<N_MATS-1, or `sum_last`=0 with `cnt`==N_MATS-1, is a mismatch:
    - pulse `proto_err` on the next cycle;
    - set `cnt`←0 and discard the partial frame;
    - stay in COLLECT.
- LAUNCH: `dec_valid_in`=1 for exactly one cycle, then go to WAIT. `sum_ready`=0.
- WAIT: `sum_ready`=0.
  - `dec_sum` is held stable from LAUNCH until WAIT exits.
  - On `dec_valid_out`: capture `dec_index`→`res_digit` and `dec_max`→`res_max`, then go to HOLD.
- HOLD: `res_valid`=1.
  - `res_digit` and `res_max` stay stable until `res_ready`.
  - On `res_valid`&&`res_ready`: set `frame_cnt`+=1 (16-bit wrap), `cnt`←0, and return to COLLECT.
- `dec_valid_out` outside WAIT is ignored. `res_ready` outside HOLD is ignored.
- No frame overlap: the next frame's first beat can be accepted in the cycle after the handshake.
- Reset values:
  - `sum_ready`=0 during reset, then 1 in COLLECT once reset is released.
  - `dec_valid_in`, `res_valid`, `proto_err` and `wdog_err` reset to 0.
  - `res_digit`, `res_max`, `dec_sum[*]` and `frame_cnt` reset to 0.
- Reset asserted mid-frame or mid-WAIT: immediate return to COLLECT with all registers cleared. A late `dec_valid_out` after reset is ignored.

## Timing
- Accept rate: one beat per cycle in COLLECT. A full frame takes N_MATS accepted beats.
- Last beat accepted at edge t: `dec_valid_in` is high in cycle t+1, and the FSM is in WAIT from t+2.
- `dec_valid_out` sampled at edge u: `res_valid`, `res_digit` and `res_max` are visible after edge u. Added latency over the argmax unit is 1 cycle.
- `proto_err` is high for the single cycle after the offending beat is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIGIT_DEC_CTRL_WDOG_EN` defined:
  - A counter runs in WAIT. If it reaches `TIMEOUT_CYC` without `dec_valid_out`, go to HOLD with `res_digit`=0, `res_max`=0 and `wdog_err`=1.
  - `wdog_err` is cleared on the HOLD handshake.
  - `frame_cnt` still increments.
- Undefined: no counter and no `wdog_err` port; WAIT waits indefinitely.

## Structure
- `digit_dec_pkg` holds:
  - the `ctrl_state_t` enum (COLLECT, LAUNCH, WAIT, HOLD);
  - default `DATA_WIDTH`/`N_MATS` constants;
  - a packed `result_t` {val, idx} shared with the argmax unit.
- The argmax unit `digit_dec` is instantiated by the parent, not inside this block.
- One natural sub-module: `digit_dec_wdog`, a loadable down-counter, instantiated only under the macro.

## Test plan
- Single frame: sums 5,9,3,40,2,7,1,0,8,6 with `sum_last` on beat 9, argmax model attached → `dec_valid_in` one pulse; `res_digit`=3, `res_max`=40; `frame_cnt`=1.
- Back-pressure: hold `res_ready`=0 for 20 cycles → `res_valid` stays high, outputs stable, `sum_ready`=0; the first beat of the next frame is accepted the cycle after the handshake.
- Early `sum_last` on beat 4 → `proto_err` pulse; the next 10-beat frame decodes correctly; `frame_cnt` is unchanged by the bad frame.
- Tie 50,50 on classes 2 and 7 → `res_digit` equals the index returned by the argmax model (2), captured unmodified.
- Reset asserted mid-WAIT, then a stray `dec_valid_out` → no `res_valid`; `frame_cnt`=0; a fresh frame decodes normally.
- With `DIGIT_DEC_CTRL_WDOG_EN`, argmax model silent → HOLD after 32 WAIT cycles with `wdog_err`=1 and `res_digit`=0; `frame_cnt` wraps 0xFFFF→0 when preloaded by force.
